// File: rtl/drum_iteration_scheduler.sv
// drum_iteration_scheduler: advances a drum-mesh column array one step per audio sample and streams the centre node
// Inputs : clk, reset (async, active-high), run (level gate on firing), strike (re-init request),
//          column_done[NUM_COLUMNS], center_node (signed 1.17), audio_ready (FIFO accept)
// Outputs: column_reset, iteration_enable (1-cycle step pulse), audio_data/audio_valid (sample handshake),
//          iter_count (steps since strike/reset), overrun (sticky missed slot), busy (not idle)
module drum_iteration_scheduler #(
    parameter int NUM_COLUMNS   = 32,
    parameter int SAMPLE_PERIOD = 1041,
    parameter int STRIKE_HOLD   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   strike,
    input  logic [NUM_COLUMNS-1:0] column_done,
    input  logic signed [17:0]     center_node,
    input  logic                   audio_ready,
    output logic                   column_reset,
    output logic                   iteration_enable,
    output logic signed [17:0]     audio_data,
    output logic                   audio_valid,
    output logic [31:0]            iter_count,
    output logic                   overrun,
    output logic                   busy
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int HW = $clog2(STRIKE_HOLD + 1);
    localparam logic [TW-1:0] PERIOD_MAX = TW'(SAMPLE_PERIOD - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(STRIKE_HOLD - 1);
    typedef enum logic [2:0] {IDLE, STRIKE, WAIT_DONE, SEND, ARM, FIRE, GUARD} state_t;
    state_t state;
    logic [TW-1:0] timer;
    logic [HW-1:0] hold;
    logic guard;
    assign busy = (state != IDLE);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            hold <= '0;
            guard <= 1'b0;
            column_reset <= 1'b0;
            iteration_enable <= 1'b0;
            audio_data <= '0;
            audio_valid <= 1'b0;
            iter_count <= '0;
            overrun <= 1'b0;
        end else begin
            timer <= (timer != '0) ? timer - 1'b1 : '0;
            // a slot is missed if the sample time arrives before the step has been delivered
            if ((state == WAIT_DONE || state == SEND) && timer == '0)
                overrun <= 1'b1;
            if (strike) begin
                // strike pre-empts everything; a strike while already striking only restarts the hold
                state <= STRIKE;
                hold <= HOLD_MAX;
                column_reset <= 1'b1;
                iteration_enable <= 1'b0;
                audio_valid <= 1'b0;
                if (state != STRIKE) begin
                    iter_count <= '0;
                    overrun <= 1'b0;
                    timer <= PERIOD_MAX;
                end
            end else begin
                case (state)
                    IDLE: if (run) state <= WAIT_DONE;
                    STRIKE: begin
                        if (hold == '0) begin
                            column_reset <= 1'b0;
                            guard <= 1'b1;
                            state <= GUARD;
                        end else begin
                            hold <= hold - 1'b1;
                        end
                    end
                    WAIT_DONE: begin
                        if (&column_done) begin
                            audio_data <= center_node;
                            audio_valid <= 1'b1;
                            state <= SEND;
                        end
                    end
                    SEND: begin
                        if (audio_ready) begin
                            audio_valid <= 1'b0;
                            state <= ARM;
                        end
                    end
                    ARM: begin
                        if (timer == '0 && run) begin
                            iteration_enable <= 1'b1;
                            iter_count <= iter_count + 32'd1;
                            timer <= PERIOD_MAX;
                            state <= FIRE;
                        end
                    end
                    FIRE: begin
                        iteration_enable <= 1'b0;
                        guard <= 1'b1;
                        state <= GUARD;
                    end
                    GUARD: begin
                        // columns still show the previous done for a cycle after the enable
                        if (guard) guard <= 1'b0;
                        else state <= WAIT_DONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_drum_iteration_scheduler.sv
// tb_drum_iteration_scheduler: directed self-checking bench with a 4-column done model
module tb_drum_iteration_scheduler;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic strike = 1'b0;
    logic [3:0] column_done;
    logic signed [17:0] center_node = '0;
    logic audio_ready = 1'b0;
    logic column_reset;
    logic iteration_enable;
    logic signed [17:0] audio_data;
    logic audio_valid;
    logic [31:0] iter_count;
    logic overrun;
    logic busy;
    int checks = 0;
    int errors = 0;
    int delay [4] = '{8, 8, 8, 8};
    int cnt [4] = '{0, 0, 0, 0};

    drum_iteration_scheduler #(
        .NUM_COLUMNS(4),
        .SAMPLE_PERIOD(20),
        .STRIKE_HOLD(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .strike(strike),
        .column_done(column_done),
        .center_node(center_node),
        .audio_ready(audio_ready),
        .column_reset(column_reset),
        .iteration_enable(iteration_enable),
        .audio_data(audio_data),
        .audio_valid(audio_valid),
        .iter_count(iter_count),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (column_reset) cnt[c] <= 0;
            else if (iteration_enable) cnt[c] <= delay[c];
            else if (cnt[c] > 0) cnt[c] <= cnt[c] - 1;
        end
    end

    always_comb begin
        column_done = '0;
        for (int c = 0; c < 4; c++) column_done[c] = (cnt[c] == 0);
    end

    task automatic wait_enable(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (iteration_enable) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({column_reset, iteration_enable, audio_valid, overrun, busy} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {column_reset, iteration_enable, audio_valid, overrun, busy});
        end
        checks++;
        if ({iter_count, audio_data} !== 50'd0) begin
            errors++;
            $display("FAIL reset_data: got count %0d data %h expected 0 0", iter_count, audio_data);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_run: busy got %b expected 0", busy);
        end
        checks++;
        if (iteration_enable !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_enable: got %b expected 0", iteration_enable);
        end
    endtask

    task automatic test_nominal();
        int hi;
        int n;
        audio_ready = 1'b1;
        run = 1'b1;
        center_node = 18'h01234;
        strike = 1'b1;
        @(negedge clk);
        strike = 1'b0;
        hi = int'(column_reset);
        repeat (8) begin
            @(negedge clk);
            hi += int'(column_reset);
        end
        checks++;
        if (hi != 4) begin
            errors++;
            $display("FAIL strike_hold: got %0d cycles expected 4", hi);
        end
        wait_enable(40, n);
        checks++;
        if (n != 12) begin
            errors++;
            $display("FAIL first_fire: got %0d expected 12", n);
        end
        for (int k = 2; k <= 10; k++) begin
            wait_enable(40, n);
            checks++;
            if (n != 20) begin
                errors++;
                $display("FAIL fire_period_%0d: got %0d expected 20", k, n);
            end
        end
        checks++;
        if (iter_count !== 32'd10) begin
            errors++;
            $display("FAIL nominal_count: got %0d expected 10", iter_count);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL nominal_overrun: got %b expected 0", overrun);
        end
        checks++;
        if (audio_data !== 18'h01234) begin
            errors++;
            $display("FAIL nominal_data: got %h expected 01234", audio_data);
        end
    endtask

    task automatic test_backpressure();
        int w;
        int bad;
        int n;
        audio_ready = 1'b0;
        center_node = 18'h0A000;
        w = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (audio_valid) begin
                w = i;
                break;
            end
        end
        checks++;
        if (w != 10) begin
            errors++;
            $display("FAIL bp_valid_rise: got %0d expected 10", w);
        end
        center_node = 18'h15555;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (audio_data !== 18'h0A000 || audio_valid !== 1'b1 || iteration_enable !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun: got %b expected 1", overrun);
        end
        audio_ready = 1'b1;
        wait_enable(10, n);
        checks++;
        if (n != 2) begin
            errors++;
            $display("FAIL bp_release_fire: got %0d expected 2", n);
        end
        checks++;
        if (iter_count !== 32'd11) begin
            errors++;
            $display("FAIL bp_count: got %0d expected 11", iter_count);
        end
    endtask

    task automatic test_strike_mid_send();
        int w;
        int hi;
        int n;
        audio_ready = 1'b0;
        w = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (audio_valid) begin
                w = i;
                break;
            end
        end
        checks++;
        if (w != 10) begin
            errors++;
            $display("FAIL ms_valid_rise: got %0d expected 10", w);
        end
        strike = 1'b1;
        @(negedge clk);
        strike = 1'b0;
        audio_ready = 1'b1;
        checks++;
        if ({audio_valid, column_reset} !== 2'b01) begin
            errors++;
            $display("FAIL ms_abort: valid/colreset got %b expected 01", {audio_valid, column_reset});
        end
        checks++;
        if (iter_count !== 32'd0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL ms_clear: got count %0d overrun %b expected 0 0", iter_count, overrun);
        end
        hi = int'(column_reset);
        repeat (6) begin
            @(negedge clk);
            hi += int'(column_reset);
        end
        checks++;
        if (hi != 4) begin
            errors++;
            $display("FAIL ms_hold: got %0d cycles expected 4", hi);
        end
        wait_enable(40, n);
        checks++;
        if (n != 14) begin
            errors++;
            $display("FAIL ms_next_fire: got %0d expected 14", n);
        end
        checks++;
        if (iter_count !== 32'd1) begin
            errors++;
            $display("FAIL ms_count: got %0d expected 1", iter_count);
        end
    endtask

    task automatic test_slow_column();
        int n;
        int bad;
        delay[2] = 25;
        bad = 0;
        n = -1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (audio_valid && column_done !== 4'hF) bad++;
            if (iteration_enable) begin
                n = i;
                break;
            end
        end
        delay[2] = 8;
        checks++;
        if (n != 29) begin
            errors++;
            $display("FAIL slow_fire: got %0d expected 29", n);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL slow_partial_send: got %0d expected 0", bad);
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL slow_overrun: got %b expected 1", overrun);
        end
        checks++;
        if (iter_count !== 32'd2) begin
            errors++;
            $display("FAIL slow_count: got %0d expected 2", iter_count);
        end
    endtask

    task automatic test_run_gating();
        int en;
        int saw;
        repeat (4) @(negedge clk);
        run = 1'b0;
        en = 0;
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            en += int'(iteration_enable);
            saw |= int'(audio_valid);
        end
        checks++;
        if (saw != 1) begin
            errors++;
            $display("FAIL gate_send: got %0d expected 1", saw);
        end
        checks++;
        if (en != 0) begin
            errors++;
            $display("FAIL gate_no_fire: got %0d expected 0", en);
        end
        checks++;
        if ({busy, audio_valid} !== 2'b10) begin
            errors++;
            $display("FAIL gate_armed: busy/valid got %b expected 10", {busy, audio_valid});
        end
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (iteration_enable !== 1'b1) begin
            errors++;
            $display("FAIL gate_resume: got %b expected 1", iteration_enable);
        end
        checks++;
        if (iter_count !== 32'd3) begin
            errors++;
            $display("FAIL gate_count: got %0d expected 3", iter_count);
        end
    endtask

    task automatic test_async_reset();
        int en;
        int n;
        reset = 1'b1;
        #1;
        checks++;
        if ({column_reset, iteration_enable, audio_valid, overrun, busy} !== 5'b0) begin
            errors++;
            $display("FAIL areset_ctrl: got %b expected 00000", {column_reset, iteration_enable, audio_valid, overrun, busy});
        end
        checks++;
        if ({iter_count, audio_data} !== 50'd0) begin
            errors++;
            $display("FAIL areset_data: got count %0d data %h expected 0 0", iter_count, audio_data);
        end
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        en = 0;
        repeat (3) begin
            @(negedge clk);
            en += int'(iteration_enable);
        end
        checks++;
        if (en != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_release: enables %0d busy %b expected 0 0", en, busy);
        end
        run = 1'b1;
        wait_enable(20, n);
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL areset_restart: got %0d expected 4", n);
        end
        checks++;
        if (iter_count !== 32'd1) begin
            errors++;
            $display("FAIL areset_count: got %0d expected 1", iter_count);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_strike_mid_send();
        test_slow_column();
        test_run_gating();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
